// File: rtl/regfile_mp_sb_if.sv
// Register-file access bus: read ports, write ports, scoreboard control
// and the debug read port. The core side is the master, the register file
// is the slave.
interface regfile_mp_sb_if #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int NUM_RD   = 3,
   parameter int NUM_WR   = 2
);
   localparam int AW = $clog2(NUM_REGS);

   logic [NUM_RD*AW-1:0]     rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_pend;
   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*AW-1:0]     wr_addr;
   logic [NUM_WR*DATA_W-1:0] wr_data;
   logic                     sb_set;
   logic [AW-1:0]            sb_addr;
   logic                     flush;
   logic                     pend_any;
   logic [AW-1:0]            dbg_addr;
   logic [DATA_W-1:0]        dbg_data;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr, flush, dbg_addr,
      input  rd_data, rd_pend, pend_any, dbg_data
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr, flush, dbg_addr,
      output rd_data, rd_pend, pend_any, dbg_data
   );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with hardwired-zero r0, optional write-to-read
// bypass and a per-register pending scoreboard used by decode to stall on
// outstanding producers.
module regfile_mp_sb #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int NUM_RD   = 3,
   parameter int NUM_WR   = 2,
   parameter int BYPASS   = 1
) (
   input logic            clk,
   input logic            rst,
   regfile_mp_sb_if.slave bus
);
   localparam int AW = $clog2(NUM_REGS);

   logic [DATA_W-1:0]        regs_q [NUM_REGS];
   logic [DATA_W-1:0]        regs_d [NUM_REGS];
   logic [NUM_REGS-1:0]      pend_q;
   logic [NUM_REGS-1:0]      pend_d;
   logic [NUM_REGS-1:0]      wr_hit_s;
   logic [NUM_REGS-1:0]      sb_mask_s;
   logic [NUM_RD*DATA_W-1:0] rd_data_s;
   logic [NUM_RD-1:0]        rd_pend_s;

   // Write decode: ascending port order so the highest-index port wins; r0 never written.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         regs_d[r]   = regs_q[r];
         wr_hit_s[r] = 1'b0;
         for (int w = 0; w < NUM_WR; w++) begin
            logic sel;
            sel = bus.wr_en[w] && (bus.wr_addr[w*AW +: AW] == AW'(r)) && (r != 0);
            regs_d[r]   = sel ? bus.wr_data[w*DATA_W +: DATA_W] : regs_d[r];
            wr_hit_s[r] = wr_hit_s[r] | sel;
         end
      end
   end

   // Scoreboard next state: writes clear, a new issue sets (set beats clear), flush beats all.
   always_comb begin
      sb_mask_s              = '0;
      sb_mask_s[bus.sb_addr] = bus.sb_set;
      sb_mask_s[0]           = 1'b0;
      pend_d                 = bus.flush ? '0 : ((pend_q & ~wr_hit_s) | sb_mask_s);
      pend_d[0]              = 1'b0;
   end

   // Read ports: array value, optionally replaced by the winning same-cycle write.
   always_comb begin
      rd_data_s = '0;
      rd_pend_s = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         logic [AW-1:0]     a;
         logic [DATA_W-1:0] d;
         logic              byp;
         a   = bus.rd_addr[i*AW +: AW];
         d   = regs_q[a];
         byp = 1'b0;
         for (int w = 0; w < NUM_WR; w++) begin
            logic m;
            m   = (BYPASS != 0) && bus.wr_en[w] && (bus.wr_addr[w*AW +: AW] == a);
            d   = m ? bus.wr_data[w*DATA_W +: DATA_W] : d;
            byp = byp | m;
         end
         rd_data_s[i*DATA_W +: DATA_W] = (a == '0) ? '0 : d;
         rd_pend_s[i]                  = pend_q[a] & ~byp;
      end
   end

   // Register array and scoreboard state; synchronous reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= '0;
         end
         pend_q <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= regs_d[r];
         end
         pend_q <= pend_d;
      end
   end

   assign bus.rd_data  = rd_data_s;
   assign bus.rd_pend  = rd_pend_s;
   assign bus.pend_any = |pend_q;
   assign bus.dbg_data = regs_q[bus.dbg_addr];
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file for the pipelined core; replaces the single-write, three-read register block.
- Provides NUM_RD combinational read ports, NUM_WR synchronous write ports, optional write-to-read bypass, a hardwired-zero register 0, and a per-register pending scoreboard.
- Decode uses the scoreboard to stall on outstanding producers (loads, multi-cycle ops).

Parameters:
- DATA_W, 16, register width in bits
- NUM_REGS, 8, number of registers (power of two, >=2)
- NUM_RD, 3, number of read ports
- NUM_WR, 2, number of write ports
- BYPASS, 1, when 1 a read returns same-cycle write data

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- rd_addr  input  NUM_RD*AW  packed read addresses, port i at [i*AW +: AW], AW=$clog2(NUM_REGS)
- rd_data  output  NUM_RD*DATA_W  packed read data
- rd_pend  output  NUM_RD  pending flag for each read port's register
- wr_en  input  NUM_WR  write enables
- wr_addr  input  NUM_WR*AW  packed write addresses
- wr_data  input  NUM_WR*DATA_W  packed write data
- sb_set  input  1  mark sb_addr pending (instruction issued)
- sb_addr  input  AW  destination register to mark
- flush  input  1  clear all pending bits (pipeline flush)
- pend_any  output  1  OR of all pending bits
- dbg_addr  input  AW  debug read address
- dbg_data  output  DATA_W  debug read data (never bypassed)

Behaviour:
- Reset (rst=1 at posedge): all registers cleared to 0 and all pending bits cleared. rd_data and dbg_data then read 0, and rd_pend and pend_any are 0 from the following cycle. rst overrides writes, sb_set and flush in the same cycle.
- Reads are combinational from rd_addr (zero latency). Writes commit at posedge, so data is visible in the array the next cycle.
- Register 0:
  - writes to it are ignored
  - it always reads 0, including through bypass
  - sb_set to it is ignored and its pending bit is always 0
- Write conflict: when several enabled ports write the same address in one cycle, the highest-index port wins. The same priority applies to bypass selection.
- Bypass, BYPASS=1: if any enabled write port targets rd_addr[i] (and the address is not 0), rd_data[i] returns the winning wr_data combinationally. BYPASS=0 returns the array value.
- Scoreboard:
  - pend[r] sets on sb_set with sb_addr=r
  - pend[r] clears on any enabled write to r
  - set and clear of the same r in the same cycle: set wins (a new producer was issued)
  - sb_set on an already-pending register: it stays pending, with no count (single outstanding producer per register)
  - flush clears every pending bit; flush and sb_set in the same cycle: flush wins, so the register is not marked
- rd_pend[i] = pend[rd_addr[i]], masked to 0 when BYPASS=1 and a same-cycle enabled write targets rd_addr[i] (the value is arriving now).
  - With BYPASS=0, rd_pend reflects only the registered state.
- pend_any is registered state only (no same-cycle masking).
- Writes to non-pending registers are legal and do not affect the scoreboard.
- Out-of-range addresses cannot occur (NUM_REGS is a power of two).

Test Plan:
- Reset then read: assert rst 1 cycle after writing 0xBEEF to r3 → rd_data for r3 = 0x0000, rd_pend=0, pend_any=0.
- Zero register: wr_en[0]=1, addr 0, data 0xFFFF; then sb_set addr 0 → reads of r0 = 0, rd_pend=0, pend_any=0.
- Dual-write conflict: ports 0 and 1 both write r5 with 0x1111 and 0x2222 → same-cycle bypass read = 0x2222, and the next-cycle array read of r5 = 0x2222.
- Bypass:
  - write r2=0x00A5 while rd_addr[1]=2 → same-cycle rd_data[1]=0x00A5
  - with BYPASS=0 the same stimulus → old value, then 0x00A5 next cycle
- Scoreboard:
  - sb_set r4 → next cycle rd_pend=1 for r4 and pend_any=1
  - write r4 → same cycle rd_pend masked to 0 and data bypassed; next cycle pend bit = 0
  - same-cycle sb_set r4 plus write r4 → pend bit stays 1
- Flush:
  - mark r1, r6 pending, then flush=1 together with sb_set r7 → next cycle all pending bits 0 and pend_any=0
  - register data for r1, r6 is unchanged
